// File: rtl/twos_complement_seq.sv
// Digit-serial two's-complement converter: pass, negate, abs, neg-abs.
// Optional saturation on overflow: define TWOS_COMPLEMENT_SATURATE_EN.
module twos_complement_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVERFLOW
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = $clog2(K + 1);

    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX = ~MIN;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             inv;
    logic             carry;
    logic             ovf_pend;
    logic             cap_inv;
    logic             accept;
    logic             finish;
    logic             last;
    logic [DIGIT-1:0] chunk;
    logic [DIGIT:0]   sum;

    assign BUSY = (state == RUN);

    // Invert enable chosen from the mode and operand sign at capture.
    always_comb begin
        cap_inv = 1'b0;
        unique case (MODE)
            2'b00: cap_inv = 1'b0;
            2'b01: cap_inv = 1'b1;
            2'b10: cap_inv = DATA_IN[WIDTH-1];
            2'b11: cap_inv = ~DATA_IN[WIDTH-1];
            default: cap_inv = 1'b0;
        endcase
    end

    // One invert-plus-carry digit step; result fills from the top down.
    always_comb begin
        chunk    = opnd[DIGIT-1:0];
        sum      = {1'b0, chunk ^ {DIGIT{inv}}} + (DIGIT+1)'(carry);
        res_next = (res >> DIGIT)
                 | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        last     = (cnt == CW'(K - 1));
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and capture/finish strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, serial datapath and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            opnd     <= '0;
            res      <= '0;
            cnt      <= '0;
            inv      <= 1'b0;
            carry    <= 1'b0;
            ovf_pend <= 1'b0;
            DATA_OUT <= '0;
            DONE     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            DONE <= finish;
            if (accept) begin
                opnd     <= DATA_IN;
                res      <= '0;
                cnt      <= '0;
                inv      <= cap_inv;
                carry    <= cap_inv;
                ovf_pend <= cap_inv && (DATA_IN == MIN);
            end else if (state == RUN) begin
                opnd  <= opnd >> DIGIT;
                res   <= res_next;
                carry <= sum[DIGIT];
                cnt   <= cnt + 1'b1;
                if (finish) begin
                    OVERFLOW <= ovf_pend;
`ifdef TWOS_COMPLEMENT_SATURATE_EN
                    DATA_OUT <= ovf_pend ? MAX : res_next;
`else
                    DATA_OUT <= res_next;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_twos_complement_seq.sv
// Scoreboard bench for twos_complement_seq, 8x1 and 16x4 instances.
// Expected results come from arithmetic negation in the bench model.
module tb_twos_complement_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8;
    logic        start16;
    logic [1:0]  mode;
    logic [7:0]  din8;
    logic [15:0] din16;
    logic [7:0]  dout8;
    logic [15:0] dout16;
    logic        busy8, done8, ovf8;
    logic        busy16, done16, ovf16;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int s8     = 0;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];

    twos_complement_seq #(.WIDTH(8), .DIGIT(1)) dut8 (
        .CLK(clk), .RESET(rst), .START(start8), .MODE(mode),
        .DATA_IN(din8), .DATA_OUT(dout8), .BUSY(busy8),
        .DONE(done8), .OVERFLOW(ovf8)
    );

    twos_complement_seq #(.WIDTH(16), .DIGIT(4)) dut16 (
        .CLK(clk), .RESET(rst), .START(start16), .MODE(mode),
        .DATA_IN(din16), .DATA_OUT(dout16), .BUSY(busy16),
        .DONE(done16), .OVERFLOW(ovf16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] model8(input logic [1:0] m,
                                          input logic [7:0] d);
        logic inv;
        logic [7:0] r;
        logic o;
        case (m)
            2'b00:   inv = 1'b0;
            2'b01:   inv = 1'b1;
            2'b10:   inv = d[7];
            default: inv = ~d[7];
        endcase
        r = inv ? (8'd0 - d) : d;
        o = inv && (d == 8'h80);
`ifdef TWOS_COMPLEMENT_SATURATE_EN
        if (o) r = 8'h7F;
`endif
        return {o, r};
    endfunction

    function automatic logic [16:0] model16(input logic [1:0] m,
                                            input logic [15:0] d);
        logic inv;
        logic [15:0] r;
        logic o;
        case (m)
            2'b00:   inv = 1'b0;
            2'b01:   inv = 1'b1;
            2'b10:   inv = d[15];
            default: inv = ~d[15];
        endcase
        r = inv ? (16'd0 - d) : d;
        o = inv && (d == 16'h8000);
`ifdef TWOS_COMPLEMENT_SATURATE_EN
        if (o) r = 16'h7FFF;
`endif
        return {o, r};
    endfunction

    // Drive a START pulse from a negedge; returns at the next negedge.
    task automatic go8(input logic [1:0] m, input logic [7:0] d,
                       input bit push);
        start8 = 1'b1;
        mode   = m;
        din8   = d;
        if (push) q8.push_back(model8(m, d));
        @(posedge clk);
        #1 s8 = cyc;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Wait (bounded) for DONE, measuring latency and BUSY-high cycles.
    task automatic wait8(output int lat, output int bn, output bit to);
        to  = 1'b1;
        bn  = 0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (done8) begin
                to  = 1'b0;
                lat = cyc - s8;
                break;
            end
            if (busy8) bn++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        start8  = 1'b1;
        start16 = 1'b1;
        mode    = 2'b01;
        din8    = 8'h55;
        din16   = 16'h5555;
        repeat (3) @(negedge clk);
        total++;
        if ({dout8, busy8, done8, ovf8} !== 11'd0) begin
            $display("FAIL reset8 got=%h want=0",
                     {dout8, busy8, done8, ovf8});
        end else passed++;
        total++;
        if ({dout16, busy16, done16, ovf16} !== 19'd0) begin
            $display("FAIL reset16 got=%h want=0",
                     {dout16, busy16, done16, ovf16});
        end else passed++;
        rst     = 1'b0;
        start8  = 1'b0;
        start16 = 1'b0;
        @(negedge clk);
        total++;
        if (busy8 !== 1'b0 || busy16 !== 1'b0) begin
            $display("FAIL reset_wins busy8=%b busy16=%b want=0 0",
                     busy8, busy16);
        end else passed++;
    endtask

    task automatic run_table(input string name,
                             input logic [9:0] tbl[]);
        int lat, bn;
        bit to;
        logic [8:0] exp;
        foreach (tbl[i]) begin
            @(negedge clk);
            go8(tbl[i][9:8], tbl[i][7:0], 1'b1);
            wait8(lat, bn, to);
            exp = q8.pop_front();
            total++;
            if (to || lat != 8) begin
                $display("FAIL %s_lat[%0d] got=%0d to=%b want=8",
                         name, i, lat, to);
            end else passed++;
            total++;
            if (bn != 8) begin
                $display("FAIL %s_busy[%0d] got=%0d want=8",
                         name, i, bn);
            end else passed++;
            total++;
            if ({ovf8, dout8} !== exp) begin
                $display("FAIL %s[%0d] got ovf=%b out=%h want ovf=%b out=%h",
                         name, i, ovf8, dout8, exp[8], exp[7:0]);
            end else passed++;
        end
    endtask

    task automatic test_modes;
        logic [9:0] tbl[];
        tbl = '{{2'b01, 8'h02}, {2'b01, 8'h00}, {2'b10, 8'hF8},
                {2'b10, 8'h05}, {2'b11, 8'h03}, {2'b00, 8'hA5},
                {2'b11, 8'hF0}};
        run_table("mode", tbl);
    endtask

    task automatic test_overflow;
        logic [9:0] tbl[];
        tbl = '{{2'b01, 8'h80}, {2'b10, 8'h80}, {2'b11, 8'h80},
                {2'b00, 8'h80}, {2'b01, 8'h7F}};
        run_table("ovf", tbl);
    endtask

    task automatic test_busy_ignore;
        int lat, bn;
        bit to;
        logic [8:0] exp;
        @(negedge clk);
        go8(2'b01, 8'h03, 1'b1);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        din8   = 8'h10;
        mode   = 2'b00;
        @(negedge clk);
        start8 = 1'b0;
        din8   = 8'h55;
        wait8(lat, bn, to);
        exp = q8.pop_front();
        total++;
        if (to || lat != 8) begin
            $display("FAIL ignore_lat got=%0d to=%b want=8", lat, to);
        end else passed++;
        total++;
        if ({ovf8, dout8} !== exp) begin
            $display("FAIL ignore got=%h want=%h", {ovf8, dout8}, exp);
        end else passed++;
    endtask

    task automatic test_back_to_back;
        int lat, bn;
        bit to;
        bit held;
        logic [8:0] exp;
        go8(2'b01, 8'h10, 1'b1);
        held = 1'b1;
        to   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done8) begin
                to  = 1'b0;
                lat = cyc - s8;
                break;
            end
            if (dout8 !== 8'hFD) held = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!held) begin
            $display("FAIL b2b_hold got=%h want=fd", dout8);
        end else passed++;
        exp = q8.pop_front();
        total++;
        if (to || lat != 8) begin
            $display("FAIL b2b_lat got=%0d to=%b want=8", lat, to);
        end else passed++;
        total++;
        if ({ovf8, dout8} !== exp) begin
            $display("FAIL b2b got=%h want=%h", {ovf8, dout8}, exp);
        end else passed++;
        @(negedge clk);
        total++;
        if (done8 !== 1'b0) begin
            $display("FAIL done_pulse got=%b want=0", done8);
        end else passed++;
    endtask

    task automatic test_reset_abort;
        int lat, bn;
        bit to;
        bit seen;
        logic [8:0] exp;
        @(negedge clk);
        go8(2'b01, 8'h07, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({dout8, busy8, done8, ovf8} !== 11'd0) begin
            $display("FAIL abort_clear got=%h want=0",
                     {dout8, busy8, done8, ovf8});
        end else passed++;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        total++;
        if (seen) begin
            $display("FAIL abort_nodone got=1 want=0");
        end else passed++;
        go8(2'b01, 8'h07, 1'b1);
        wait8(lat, bn, to);
        exp = q8.pop_front();
        total++;
        if (to || lat != 8) begin
            $display("FAIL abort_lat got=%0d to=%b want=8", lat, to);
        end else passed++;
        total++;
        if ({ovf8, dout8} !== exp) begin
            $display("FAIL abort_restart got=%h want=%h",
                     {ovf8, dout8}, exp);
        end else passed++;
    endtask

    task automatic test_wide;
        logic [17:0] tbl[];
        logic [16:0] exp;
        int s, lat;
        bit to;
        tbl = '{{2'b01, 16'h1234}, {2'b10, 16'h8000},
                {2'b11, 16'h0001}, {2'b10, 16'hFF00}};
        foreach (tbl[i]) begin
            @(negedge clk);
            start16 = 1'b1;
            mode    = tbl[i][17:16];
            din16   = tbl[i][15:0];
            q16.push_back(model16(tbl[i][17:16], tbl[i][15:0]));
            @(posedge clk);
            #1 s = cyc;
            @(negedge clk);
            start16 = 1'b0;
            to  = 1'b1;
            lat = 0;
            for (int j = 0; j < 40; j++) begin
                if (done16) begin
                    to  = 1'b0;
                    lat = cyc - s;
                    break;
                end
                @(negedge clk);
            end
            exp = q16.pop_front();
            total++;
            if (to || lat != 4) begin
                $display("FAIL wide_lat[%0d] got=%0d to=%b want=4",
                         i, lat, to);
            end else passed++;
            total++;
            if ({ovf16, dout16} !== exp) begin
                $display("FAIL wide[%0d] got=%h want=%h",
                         i, {ovf16, dout16}, exp);
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_wide();
        total++;
        if (q8.size() != 0 || q16.size() != 0) begin
            $display("FAIL queue_left got=%0d want=0",
                     q8.size() + q16.size());
        end else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
